// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared types and constants for the ROM port arbiter.
//   state_t   - arbiter FSM states
//   grant_t   - identity of the requester served most recently
//   *_DEFAULT - default byte offsets of each CPU's ROM image in memory
package rom_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 24;

  localparam logic [ADDR_W-1:0] M68K_BASE_DEFAULT = 24'h000000;
  localparam logic [ADDR_W-1:0] Z80_BASE_DEFAULT  = 24'h040000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_68K = 2'd1,
    BUSY_Z80 = 2'd2
  } state_t;

  typedef enum logic {
    GNT_68K = 1'b0,
    GNT_Z80 = 1'b1
  } grant_t;

endpackage

// File: rtl/rom_port_buffer.sv
// rom_port_buffer: one-word fetch buffer for a single ROM requester.
//   clk, rst_n  - clock, asynchronous active-low reset
//   fill        - write fill_tag/fill_data and mark the entry valid
//   lookup_tag  - word address currently presented by the CPU
//   hit         - entry valid and its tag matches lookup_tag
//   data        - buffered word (0 after reset)
module rom_port_buffer
  import rom_arbiter_pkg::*;
#(
  parameter int TAG_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic              valid_r;
  logic [TAG_W-1:0]  tag_r;
  logic [DATA_W-1:0] data_r;

  // Buffer storage: written only when a fetch for this requester completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      tag_r   <= '0;
      data_r  <= '0;
    end else if (fill) begin
      valid_r <= 1'b1;
      tag_r   <= fill_tag;
      data_r  <= fill_data;
    end else begin
      valid_r <= valid_r;
      tag_r   <= tag_r;
      data_r  <= data_r;
    end
  end

  assign hit  = valid_r & (tag_r == lookup_tag);
  assign data = data_r;

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one SDRAM read port between the 68K program-ROM and
// the Z80 sound-ROM fetch paths, with a one-word buffer per requester.
//   clk_sys, reset_n            - clock, asynchronous active-low reset
//   m68k_rom_cs, m68k_a         - 68K select and word address
//   m68k_rom_dout, _dtack_n     - buffered word, low when the word is valid
//   z80_rom_cs, z80_addr        - Z80 select and byte address
//   z80_rom_dout, z80_wait_n    - buffered byte, low to stall the Z80
//   mem_req, mem_addr           - registered request, held until mem_ack
//   mem_ack, mem_data           - one-cycle acknowledge with read data
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter logic [23:0] M68K_BASE = M68K_BASE_DEFAULT,
  parameter logic [23:0] Z80_BASE  = Z80_BASE_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        m68k_rom_cs,
  input  logic [22:0] m68k_a,
  output logic [15:0] m68k_rom_dout,
  output logic        m68k_rom_dtack_n,
  input  logic        z80_rom_cs,
  input  logic [15:0] z80_addr,
  output logic [7:0]  z80_rom_dout,
  output logic        z80_wait_n,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data
);

  state_t      state_r, state_nxt_s;
  grant_t      last_grant_r, last_grant_nxt_s;
  logic        mem_req_r, mem_req_nxt_s;
  logic [23:0] mem_addr_r, mem_addr_nxt_s;
  // Word tag of the fetch in flight; the Z80 uses only the low 15 bits.
  logic [22:0] req_tag_r, req_tag_nxt_s;
  logic        fill_68k_s, fill_z80_s;
  logic        hit_68k_s, hit_z80_s;
  logic        pend_68k_s, pend_z80_s;
  logic [15:0] data_68k_s, data_z80_s;

  rom_port_buffer #(.TAG_W(23)) u_buf_68k (
    .clk        (clk_sys),
    .rst_n      (reset_n),
    .fill       (fill_68k_s),
    .fill_tag   (req_tag_r),
    .fill_data  (mem_data),
    .lookup_tag (m68k_a),
    .hit        (hit_68k_s),
    .data       (data_68k_s)
  );

  rom_port_buffer #(.TAG_W(15)) u_buf_z80 (
    .clk        (clk_sys),
    .rst_n      (reset_n),
    .fill       (fill_z80_s),
    .fill_tag   (req_tag_r[14:0]),
    .fill_data  (mem_data),
    .lookup_tag (z80_addr[15:1]),
    .hit        (hit_z80_s),
    .data       (data_z80_s)
  );

  assign pend_68k_s = m68k_rom_cs & ~hit_68k_s;
  assign pend_z80_s = z80_rom_cs & ~hit_z80_s;

  assign m68k_rom_dtack_n = ~(m68k_rom_cs & hit_68k_s);
  assign z80_wait_n       = ~pend_z80_s;
  assign m68k_rom_dout    = data_68k_s;
  assign z80_rom_dout     = z80_addr[0] ? data_z80_s[15:8] : data_z80_s[7:0];
  assign mem_req          = mem_req_r;
  assign mem_addr         = mem_addr_r;

  // Arbiter state and registered memory-port outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      last_grant_r <= GNT_Z80;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= 24'h000000;
      req_tag_r    <= 23'h000000;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      mem_req_r    <= mem_req_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      req_tag_r    <= req_tag_nxt_s;
    end
  end

  // Round-robin grant from IDLE; buffer fill and release on mem_ack.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    mem_req_nxt_s    = mem_req_r;
    mem_addr_nxt_s   = mem_addr_r;
    req_tag_nxt_s    = req_tag_r;
    fill_68k_s       = 1'b0;
    fill_z80_s       = 1'b0;
    case (state_r)
      IDLE: begin
        // On a tie the 68K wins only if the Z80 was served last.
        if (pend_68k_s && (!pend_z80_s || (last_grant_r == GNT_Z80))) begin
          state_nxt_s    = BUSY_68K;
          mem_req_nxt_s  = 1'b1;
          mem_addr_nxt_s = M68K_BASE + {m68k_a, 1'b0};
          req_tag_nxt_s  = m68k_a;
        end else if (pend_z80_s) begin
          state_nxt_s    = BUSY_Z80;
          mem_req_nxt_s  = 1'b1;
          mem_addr_nxt_s = Z80_BASE + {8'h00, z80_addr[15:1], 1'b0};
          req_tag_nxt_s  = {8'h00, z80_addr[15:1]};
        end else begin
          state_nxt_s    = IDLE;
        end
      end
      BUSY_68K: begin
        if (mem_ack) begin
          fill_68k_s       = 1'b1;
          mem_req_nxt_s    = 1'b0;
          last_grant_nxt_s = GNT_68K;
          state_nxt_s      = IDLE;
        end else begin
          state_nxt_s      = BUSY_68K;
        end
      end
      BUSY_Z80: begin
        if (mem_ack) begin
          fill_z80_s       = 1'b1;
          mem_req_nxt_s    = 1'b0;
          last_grant_nxt_s = GNT_Z80;
          state_nxt_s      = IDLE;
        end else begin
          state_nxt_s      = BUSY_Z80;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        mem_req_nxt_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed scenarios with literal expectations, then a
// randomized phase; every cycle the DUT is compared to a behavioural model.
module tb_rom_arbiter;

  localparam logic [23:0] M68K_BASE = 24'h000000;
  localparam logic [23:0] Z80_BASE  = 24'h040000;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        m68k_rom_cs;
  logic [22:0] m68k_a;
  logic [15:0] m68k_rom_dout;
  logic        m68k_rom_dtack_n;
  logic        z80_rom_cs;
  logic [15:0] z80_addr;
  logic [7:0]  z80_rom_dout;
  logic        z80_wait_n;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;

  int n_chk = 0;
  int n_fail = 0;
  bit auto_resp = 1'b0;
  bit cmp_en = 1'b0;
  int wait_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  rom_arbiter #(.M68K_BASE(M68K_BASE), .Z80_BASE(Z80_BASE)) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .m68k_rom_cs      (m68k_rom_cs),
    .m68k_a           (m68k_a),
    .m68k_rom_dout    (m68k_rom_dout),
    .m68k_rom_dtack_n (m68k_rom_dtack_n),
    .z80_rom_cs       (z80_rom_cs),
    .z80_addr         (z80_addr),
    .z80_rom_dout     (z80_rom_dout),
    .z80_wait_n       (z80_wait_n),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_data         (mem_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buffers per requester; who is being served (0 none, 1 68K, 2 Z80);
  // who was served last; address presented to memory.
  logic        mv68, mvz;
  logic [22:0] mt68;
  logic [14:0] mtz;
  logic [15:0] md68, mdz;
  logic [1:0]  m_serving;
  logic [1:0]  m_last;
  logic [23:0] m_addr;
  logic [22:0] m_tag;
  logic        mh68, mhz, mp68, mpz;

  always_comb begin
    mh68 = mv68 && (mt68 == m68k_a);
    mhz  = mvz && (mtz == z80_addr[15:1]);
    mp68 = m68k_rom_cs && !mh68;
    mpz  = z80_rom_cs && !mhz;
  end

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mv68 <= 1'b0; mvz <= 1'b0; mt68 <= '0; mtz <= '0;
      md68 <= 16'h0000; mdz <= 16'h0000;
      m_serving <= 2'd0; m_last <= 2'd2;
      m_addr <= 24'h000000; m_tag <= '0;
    end else if (m_serving == 2'd0) begin
      if (mp68 && (!mpz || m_last == 2'd2)) begin
        m_serving <= 2'd1;
        m_addr <= M68K_BASE + 24'(m68k_a) * 24'd2;
        m_tag <= m68k_a;
      end else if (mpz) begin
        m_serving <= 2'd2;
        m_addr <= Z80_BASE + 24'(z80_addr) - 24'(z80_addr[0]);
        m_tag <= 23'(z80_addr[15:1]);
      end
    end else if (mem_ack) begin
      if (m_serving == 2'd1) begin
        mv68 <= 1'b1; mt68 <= m_tag; md68 <= mem_data;
      end else begin
        mvz <= 1'b1; mtz <= m_tag[14:0]; mdz <= mem_data;
      end
      m_last <= m_serving;
      m_serving <= 2'd0;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk_sys) begin
    if (cmp_en) begin
      chk("cyc_mem_req", 32'(mem_req), 32'(m_serving != 2'd0));
      chk("cyc_mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("cyc_dtack_n", 32'(m68k_rom_dtack_n), 32'(!(m68k_rom_cs && mh68)));
      chk("cyc_wait_n", 32'(z80_wait_n), 32'(!mpz));
      chk("cyc_m68k_dout", 32'(m68k_rom_dout), 32'(md68));
      chk("cyc_z80_dout", 32'(z80_rom_dout), 32'(z80_addr[0] ? mdz[15:8] : mdz[7:0]));
    end
  end

  function automatic logic [15:0] gen_data(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
  endfunction

  // Advance one clock; inputs change 1 ns after the edge. In auto mode this
  // also acts as the memory, acking after 0..3 cycles, with stray idle acks.
  task automatic step();
    @(posedge clk_sys);
    #1;
    mem_ack = 1'b0;
    if (auto_resp) begin
      if (!mem_req) begin
        wait_cnt = int'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) begin
          mem_ack = 1'b1;
          mem_data = 16'($urandom);
        end
      end else if (wait_cnt == 0) begin
        mem_ack = 1'b1;
        mem_data = gen_data(mem_addr);
        wait_cnt = int'($urandom_range(0, 3));
      end else begin
        wait_cnt--;
      end
    end
  endtask

  task automatic ack(input logic [15:0] d);
    step();
    mem_ack = 1'b1;
    mem_data = d;
  endtask

  initial begin
    m68k_rom_cs = 1'b0; m68k_a = '0; z80_rom_cs = 1'b0; z80_addr = 16'h0000;
    mem_ack = 1'b0; mem_data = 16'h0000; reset_n = 1'b1;
    #2 reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_m68k_dout", 32'(m68k_rom_dout), 32'h0);
    chk("rst_z80_dout", 32'(z80_rom_dout), 32'h0);
    chk("rst_dtack_n", 32'(m68k_rom_dtack_n), 32'h1);
    chk("rst_wait_n", 32'(z80_wait_n), 32'h1);

    // 68K miss, fetch, then hit
    step(); m68k_rom_cs = 1'b1; m68k_a = 23'h000010;
    #1 chk("m68_miss_dtack", 32'(m68k_rom_dtack_n), 32'h1);
    step();
    chk("m68_req", 32'(mem_req), 32'h1);
    chk("m68_addr", 32'(mem_addr), 32'h000020);
    step(); ack(16'h4E71);
    step();
    chk("m68_hit_dtack", 32'(m68k_rom_dtack_n), 32'h0);
    chk("m68_hit_dout", 32'(m68k_rom_dout), 32'h4E71);
    step();
    chk("m68_repeat_noreq", 32'(mem_req), 32'h0);
    m68k_rom_cs = 1'b0;

    // Z80 miss, fetch high byte, then low byte hit
    step(); z80_rom_cs = 1'b1; z80_addr = 16'h0003;
    #1 chk("z80_miss_wait", 32'(z80_wait_n), 32'h0);
    step();
    chk("z80_addr", 32'(mem_addr), 32'h040002);
    ack(16'hBEEF);
    step();
    chk("z80_hit_wait", 32'(z80_wait_n), 32'h1);
    chk("z80_hi_byte", 32'(z80_rom_dout), 32'hBE);
    z80_addr = 16'h0002;
    #1 chk("z80_lo_byte", 32'(z80_rom_dout), 32'hEF);
    z80_rom_cs = 1'b0;

    // Simultaneous misses after reset: 68K first, then Z80
    step(); reset_n = 1'b0;
    step(); reset_n = 1'b1;
    m68k_rom_cs = 1'b1; m68k_a = 23'h000100; z80_rom_cs = 1'b1; z80_addr = 16'h0200;
    step(); chk("tie1_68k", 32'(mem_addr), 32'h000200);
    ack(16'h1111);
    step(); chk("tie1_gap", 32'(mem_req), 32'h0);
    step(); chk("tie1_z80", 32'(mem_addr), 32'h040200);
    ack(16'h2222);
    step();
    m68k_a = 23'h000101; z80_addr = 16'h0204;
    step(); chk("tie2_68k", 32'(mem_addr), 32'h000202);
    ack(16'h3333);
    step(); step(); chk("tie2_z80", 32'(mem_addr), 32'h040204);
    ack(16'h4444);
    step();
    z80_rom_cs = 1'b0; m68k_a = 23'h000102;
    step(); chk("solo_68k", 32'(mem_addr), 32'h000204);
    ack(16'h5555);
    step();
    m68k_a = 23'h000103; z80_rom_cs = 1'b1; z80_addr = 16'h0206;
    step(); chk("tie3_z80", 32'(mem_addr), 32'h040206);
    ack(16'h6666);
    step(); step(); chk("tie3_68k", 32'(mem_addr), 32'h000206);
    ack(16'h7777);
    step();
    m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0;

    // 68K deselects mid-fetch: fetch still completes and fills
    m68k_a = 23'h000200; m68k_rom_cs = 1'b1;
    step(); chk("drop_busy", 32'(mem_req), 32'h1);
    step(); step(); m68k_rom_cs = 1'b0;
    step(); chk("drop_held", 32'(mem_req), 32'h1);
    chk("drop_addr", 32'(mem_addr), 32'h000400);
    ack(16'h1234);
    step(); chk("drop_done", 32'(mem_req), 32'h0);
    m68k_rom_cs = 1'b1;
    #1 chk("drop_filled", 32'(m68k_rom_dout), 32'h1234);
    m68k_a = 23'h000201;
    step(); chk("drop_new_addr", 32'(mem_addr), 32'h000402);
    ack(16'h5678);
    step(); m68k_rom_cs = 1'b0;

    // Reset while serving the Z80
    z80_rom_cs = 1'b1; z80_addr = 16'h0300;
    step(); chk("rstbusy_req", 32'(mem_req), 32'h1);
    reset_n = 1'b0;
    #1 chk("rstbusy_drop", 32'(mem_req), 32'h0);
    step(); reset_n = 1'b1; z80_addr = 16'h0002;
    #1 chk("rstbusy_miss", 32'(z80_wait_n), 32'h0);
    step(); chk("rstbusy_refetch", 32'(mem_addr), 32'h040002);
    ack(16'h9999);
    step(); z80_rom_cs = 1'b0;

    // Stray ack while idle changes nothing
    mem_ack = 1'b1; mem_data = 16'hFFFF;
    step(); step();
    chk("idle_ack_req", 32'(mem_req), 32'h0);
    chk("idle_ack_z80", 32'(z80_rom_dout), 32'h99);
    chk("idle_ack_m68", 32'(m68k_rom_dout), 32'h0);

    // Randomized traffic over small address pools so hits recur
    auto_resp = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      m68k_rom_cs = ($urandom_range(0, 3) != 0);
      z80_rom_cs  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) m68k_a = 23'h000010 + 23'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) z80_addr = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
    end
    auto_resp = 1'b0;
    reset_n = 1'b1;
    step(); step();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
